vend_sequencer: RTL and testbench

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_pkg.sv | 18 +
 rtl/coin_arbiter.sv | 39 +++
 rtl/vend_sequencer.sv | 162 ++++++++++++++++
 tb/tb_vend_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: FSM state encoding, coin values
// and change denominations (all in cents, 8-bit so credit sums never wrap).
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VEND   = 2'd1,
      ST_CHANGE = 2'd2
   } state_e;

   localparam logic [7:0] COIN_QUARTER  = 8'd25;
   localparam logic [7:0] COIN_DIME     = 8'd10;
   localparam logic [7:0] COIN_NICKEL   = 8'd5;

   localparam logic [7:0] CHANGE_DIME   = 8'd10;
   localparam logic [7:0] CHANGE_NICKEL = 8'd5;

endpackage

// File: rtl/coin_arbiter.sv
// Coin-sensor rising-edge detection with quarter > dime > nickel arbitration.
// Reports the value of the single winning coin and whether any other edge lost.
module coin_arbiter
   import vend_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       quarter_i,
   input  logic       dime_i,
   input  logic       nickel_i,
   output logic [7:0] coin_val_o,
   output logic       lose_o
);

   logic [2:0] hist_q;
   logic [2:0] edge_w;

   always_ff @(posedge clk) begin
      if (!reset) hist_q <= '0;
      else        hist_q <= {quarter_i, dime_i, nickel_i};
   end

   assign edge_w = {quarter_i, dime_i, nickel_i} & ~hist_q;

   always_comb begin
      coin_val_o = '0;
      lose_o     = 1'b0;
      if (edge_w[2]) begin
         coin_val_o = COIN_QUARTER;
         lose_o     = |edge_w[1:0];
      end else if (edge_w[1]) begin
         coin_val_o = COIN_DIME;
         lose_o     = edge_w[0];
      end else if (edge_w[0]) begin
         coin_val_o = COIN_NICKEL;
      end
   end

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: credit accumulation, product dispense with timeout, and
// change payout (dimes first, then nickels, one pulse every two cycles).
//
// state     | meaning
// ST_IDLE   | accept coins, wait for a qualifying select or coin_return
// ST_VEND   | Give* held until dispense_done or timeout
// ST_CHANGE | pay out remaining credit, then return to idle
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int PRICE_SODA   = 50,
   parameter int PRICE_DIET   = 50,
   parameter int MAX_CREDIT   = 100,
   parameter int DISP_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       quarter,
   input  logic       dime,
   input  logic       nickel,
   input  logic       soda,
   input  logic       diet,
   input  logic       coin_return,
   input  logic       dispense_done,
   output logic       GiveSoda,
   output logic       GiveDiet,
   output logic       change_dime,
   output logic       change_nickel,
   output logic [6:0] credit,
   output logic       busy,
   output logic       coin_reject,
   output logic       fault
);

   localparam int         TW       = $clog2(DISP_TIMEOUT + 1);
   localparam logic [TW-1:0] TMR_LOAD = TW'(DISP_TIMEOUT - 1);
   localparam logic [7:0] PRICE_S8 = 8'(PRICE_SODA);
   localparam logic [7:0] PRICE_D8 = 8'(PRICE_DIET);
   localparam logic [7:0] MAX_C8   = 8'(MAX_CREDIT);

   logic [7:0]    coin_val;
   logic          coin_lose;
   logic          coin_ok;

   state_e        state_q, state_d;
   logic [7:0]    credit_q, credit_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          diet_q, diet_d;
   logic          phase_q, phase_d;
   logic          rej_q, rej_d;
   logic          fault_q, fault_d;
   logic          cd_q, cd_d;
   logic          cn_q, cn_d;

   coin_arbiter u_coin_arbiter (
      .clk        (clk),
      .reset      (reset),
      .quarter_i  (quarter),
      .dime_i     (dime),
      .nickel_i   (nickel),
      .coin_val_o (coin_val),
      .lose_o     (coin_lose)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         credit_q <= '0;
         tmr_q    <= '0;
         diet_q   <= 1'b0;
         phase_q  <= 1'b0;
         rej_q    <= 1'b0;
         fault_q  <= 1'b0;
         cd_q     <= 1'b0;
         cn_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         tmr_q    <= tmr_d;
         diet_q   <= diet_d;
         phase_q  <= phase_d;
         rej_q    <= rej_d;
         fault_q  <= fault_d;
         cd_q     <= cd_d;
         cn_q     <= cn_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      tmr_d    = tmr_q;
      diet_d   = diet_q;
      phase_d  = phase_q;
      fault_d  = 1'b0;
      cd_d     = 1'b0;
      cn_d     = 1'b0;

      // Coins only count in idle and only while they keep credit within the ceiling.
      coin_ok = (state_q == ST_IDLE) && (coin_val != 8'd0) &&
                ((credit_q + coin_val) <= MAX_C8);
      rej_d   = coin_lose || ((coin_val != 8'd0) && !coin_ok);

      case (state_q)
         ST_IDLE: begin
            if (coin_ok) credit_d = credit_q + coin_val;
            if (soda && (credit_q >= PRICE_S8)) begin
               state_d = ST_VEND;
               diet_d  = 1'b0;
               tmr_d   = TMR_LOAD;
            end else if (diet && (credit_q >= PRICE_D8)) begin
               state_d = ST_VEND;
               diet_d  = 1'b1;
               tmr_d   = TMR_LOAD;
            end else if (coin_return && (credit_q != 8'd0)) begin
               state_d = ST_CHANGE;
               phase_d = 1'b0;
            end
         end
         ST_VEND: begin
            if (dispense_done) begin
               credit_d = credit_q - (diet_q ? PRICE_D8 : PRICE_S8);
               state_d  = ST_CHANGE;
               phase_d  = 1'b0;
            end else if (tmr_q == '0) begin
               fault_d = 1'b1;
               state_d = ST_CHANGE;
               phase_d = 1'b0;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         ST_CHANGE: begin
            if (credit_q == 8'd0) begin
               state_d = ST_IDLE;
            end else if (!phase_q) begin
               phase_d = 1'b1;
               if (credit_q >= CHANGE_DIME) begin
                  cd_d     = 1'b1;
                  credit_d = credit_q - CHANGE_DIME;
               end else begin
                  cn_d     = 1'b1;
                  credit_d = (credit_q >= CHANGE_NICKEL) ? credit_q - CHANGE_NICKEL : 8'd0;
               end
            end else begin
               phase_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign GiveSoda      = (state_q == ST_VEND) && !diet_q;
   assign GiveDiet      = (state_q == ST_VEND) && diet_q;
   assign busy          = (state_q != ST_IDLE);
   assign credit        = credit_q[6:0];
   assign change_dime   = cd_q;
   assign change_nickel = cn_q;
   assign coin_reject   = rej_q;
   assign fault         = fault_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: the driver predicts output events from a
// credit-level model and queues them; a negedge monitor pops and compares them.
module tb_vend_sequencer;

   localparam int PS   = 50;
   localparam int PD   = 50;
   localparam int MAXC = 100;
   localparam int TO   = 255;

   localparam int EV_REJ   = 0;
   localparam int EV_SODA  = 1;
   localparam int EV_DIET  = 2;
   localparam int EV_DIME  = 3;
   localparam int EV_NICK  = 4;
   localparam int EV_FAULT = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, quarter, dime, nickel, soda, diet, coin_return, dispense_done;
   logic       GiveSoda, GiveDiet, change_dime, change_nickel, busy, coin_reject, fault;
   logic [6:0] credit;

   vend_sequencer #(
      .PRICE_SODA(PS), .PRICE_DIET(PD), .MAX_CREDIT(MAXC), .DISP_TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .quarter(quarter), .dime(dime), .nickel(nickel),
      .soda(soda), .diet(diet), .coin_return(coin_return), .dispense_done(dispense_done),
      .GiveSoda(GiveSoda), .GiveDiet(GiveDiet), .change_dime(change_dime),
      .change_nickel(change_nickel), .credit(credit), .busy(busy),
      .coin_reject(coin_reject), .fault(fault)
   );

   typedef struct {
      int kind;
      int cr;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  m_credit = 0;
   int  cyc      = 0;
   int  last_pulse = -1;
   logic prev_gs = 1'b0;
   logic prev_gd = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void push_ev(input int k, input int c);
      ev_t e;
      e.kind = k;
      e.cr   = c;
      exp_q.push_back(e);
   endfunction

   // Change is paid as dimes while 10 or more remains, then nickels.
   function automatic void push_refund(input int r);
      int rem = r;
      while (rem > 0) begin
         if (rem >= 10) begin rem -= 10; push_ev(EV_DIME, rem); end
         else           begin rem -= 5;  push_ev(EV_NICK, rem); end
      end
   endfunction

   task automatic observe(input int k);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d credit %0d, expected none", k, credit);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", k, e.kind);
         check("event_credit", int'(credit), e.cr);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (fault)                 observe(EV_FAULT);
      if (coin_reject)           observe(EV_REJ);
      if (GiveSoda && !prev_gs)  observe(EV_SODA);
      if (GiveDiet && !prev_gd)  observe(EV_DIET);
      if (change_dime || change_nickel) begin
         if (last_pulse >= 0) check("pulse_gap", cyc - last_pulse, 2);
         last_pulse = cyc;
         observe(change_dime ? EV_DIME : EV_NICK);
      end
      if (!busy) last_pulse = -1;
      prev_gs = GiveSoda;
      prev_gd = GiveDiet;
   end

   task automatic check_all_zero(input string name);
      check(name, int'({GiveSoda, GiveDiet, change_dime, change_nickel, busy, coin_reject, fault}), 0);
      check({name, "_credit"}, int'(credit), 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      {quarter, dime, nickel, soda, diet, coin_return, dispense_done} = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset_outputs");
      reset = 1'b1;
      m_credit = 0;
      @(negedge clk);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", int'(busy), 0);
   endtask

   // m = {quarter, dime, nickel}
   task automatic coin(input logic [2:0] m);
      int val;
      bit rej;
      val = m[2] ? 25 : (m[1] ? 10 : (m[0] ? 5 : 0));
      rej = (m[2] && (m[1] || m[0])) || (m[1] && m[0]);
      if (val != 0 && m_credit + val > MAXC) rej = 1'b1;
      else m_credit += val;
      if (rej) push_ev(EV_REJ, m_credit);
      {quarter, dime, nickel} = m;
      @(negedge clk);
      {quarter, dime, nickel} = '0;
      check("credit_after_coin", int'(credit), m_credit);
      @(negedge clk);
   endtask

   task automatic ret();
      coin_return = 1'b1;
      if (m_credit > 0) push_refund(m_credit);
      @(negedge clk);
      coin_return = 1'b0;
      m_credit = 0;
      wait_idle(200);
      check("credit_after_return", int'(credit), 0);
      @(negedge clk);
   endtask

   task automatic buy(input bit s, input bit dt, input int d, input bit coin_during, input bit timeout);
      bit go = 1'b0;
      bit is_diet = 1'b0;
      bit cd;
      int price = 0;
      int held;
      if (s && m_credit >= PS)       begin go = 1'b1; is_diet = 1'b0; price = PS; end
      else if (dt && m_credit >= PD) begin go = 1'b1; is_diet = 1'b1; price = PD; end
      soda = s;
      diet = dt;
      if (go) push_ev(is_diet ? EV_DIET : EV_SODA, m_credit);
      @(negedge clk);
      soda = 1'b0;
      diet = 1'b0;
      if (!go) begin
         check("no_vend_busy", int'(busy), 0);
         @(negedge clk);
         return;
      end
      check("give_asserted", int'(is_diet ? GiveDiet : GiveSoda), 1);
      if (timeout) begin
         push_ev(EV_FAULT, m_credit);
         push_refund(m_credit);
         held = 0;
         while ((GiveSoda || GiveDiet) && held < TO + 20) begin
            held++;
            @(negedge clk);
         end
         check("give_timeout_cycles", held, TO);
      end else begin
         cd = coin_during && (d >= 2);
         if (cd) push_ev(EV_REJ, m_credit);
         held = 1;
         while (held < d) begin
            if (held == 1 && cd) dime = 1'b1;
            @(negedge clk);
            dime = 1'b0;
            held++;
            check("give_held", int'(is_diet ? GiveDiet : GiveSoda), 1);
         end
         push_refund(m_credit - price);
         dispense_done = 1'b1;
         @(negedge clk);
         dispense_done = 1'b0;
         check("give_dropped", int'(GiveSoda | GiveDiet), 0);
      end
      m_credit = 0;
      wait_idle(200);
      check("credit_after_vend", int'(credit), 0);
      @(negedge clk);
   endtask

   task automatic reset_mid_change();
      coin(3'b100); coin(3'b100); coin(3'b100); coin(3'b100);
      coin_return = 1'b1;
      push_ev(EV_DIME, m_credit - 10);
      @(negedge clk);
      coin_return = 1'b0;
      begin
         int n = 0;
         while (!change_dime && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      check("first_dime_seen", int'(change_dime), 1);
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset_abort");
      reset = 1'b1;
      m_credit = 0;
      repeat (20) @(negedge clk);
      check("idle_after_abort", int'(busy), 0);
      check("credit_after_abort", int'(credit), 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      coin(3'b100); coin(3'b100);
      buy(1'b1, 1'b0, 3, 1'b0, 1'b0);

      coin(3'b111);
      ret();

      coin(3'b100); coin(3'b100); coin(3'b100);
      buy(1'b0, 1'b1, 2, 1'b0, 1'b0);

      coin(3'b100); coin(3'b100); coin(3'b100); coin(3'b100);
      coin(3'b001);
      ret();

      coin(3'b100); coin(3'b100);
      buy(1'b1, 1'b0, 0, 1'b0, 1'b1);

      coin(3'b100); coin(3'b010); coin(3'b010); coin(3'b001);
      buy(1'b1, 1'b1, 4, 1'b1, 1'b0);

      reset_mid_change();

      for (int i = 0; i < 60; i++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op <= 5)
            coin(3'($urandom_range(1, 7)));
         else if (op <= 7)
            buy(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 1'b0);
         else
            ret();
      end
      ret();

      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
